// File: rtl/d_cache_pkg.sv
// Shared geometry, address-split helpers and lookup/replacement types for the D-cache tag controller.
// DCACHE_PLRU_EN selects tree pseudo-LRU replacement state; otherwise a round-robin pointer per set.
package d_cache_pkg;

  localparam int DC_ADDR_W   = 32;
  localparam int DC_SETS     = 4;
  localparam int DC_WAYS     = 4;
  localparam int DC_OFFSET_W = 2;
  localparam int DC_SET_W    = $clog2(DC_SETS);
  localparam int DC_WAY_W    = $clog2(DC_WAYS);
  localparam int DC_TAG_W    = DC_ADDR_W - DC_SET_W - DC_OFFSET_W;

  typedef struct packed {
    logic                hit;
    logic [DC_WAY_W-1:0] way;
    logic [DC_WAY_W-1:0] victim;
  } lookup_rsp_t;

`ifdef DCACHE_PLRU_EN
  typedef logic [DC_WAYS-2:0] repl_state_t;
`else
  typedef logic [DC_WAY_W-1:0] repl_state_t;
`endif

  function automatic logic [DC_TAG_W-1:0] addr_tag(input logic [DC_ADDR_W-1:0] addr);
    return addr[DC_ADDR_W-1 -: DC_TAG_W];
  endfunction

  function automatic logic [DC_SET_W-1:0] addr_set(input logic [DC_ADDR_W-1:0] addr);
    return addr[DC_OFFSET_W +: DC_SET_W];
  endfunction

  function automatic logic [DC_OFFSET_W-1:0] addr_offset(input logic [DC_ADDR_W-1:0] addr);
    return addr[DC_OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/d_plru_tree.sv
// Tree pseudo-LRU for one set: picks the victim way and applies a hit touch followed by a fill touch.
// Instantiated by d_sa_tag_ctrl only when DCACHE_PLRU_EN is defined.
module d_plru_tree #(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  state,
  input  logic             hit_en,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             fill_en,
  input  logic [WAY_W-1:0] fill_way,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-2:0]  state_next
);

  // Heap-ordered nodes (root 0, children 2n+1 / 2n+2); a set bit steers the victim right.
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] st, input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] r;
    logic            b;
    int              idx;
    r   = st;
    idx = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = way[WAY_W-1-l];
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == idx) r[n] = ~b;
      end
      idx = 2*idx + 1 + int'(b);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] pick(input logic [WAYS-2:0] st);
    logic [WAY_W-1:0] v;
    logic             b;
    int               idx;
    v   = '0;
    idx = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == idx) b = st[n];
      end
      v[WAY_W-1-l] = b;
      idx = 2*idx + 1 + int'(b);
    end
    return v;
  endfunction

  logic [WAYS-2:0] st_hit;

  assign victim = pick(state);

  always_comb begin
    st_hit     = hit_en ? touch(state, hit_way) : state;
    state_next = fill_en ? touch(st_hit, fill_way) : st_hit;
  end

endmodule

// File: rtl/d_sa_tag_ctrl.sv
// Set-associative D-cache tag/valid controller: registered lookups, refill writes, sequenced invalidate-all.
// Build option DCACHE_PLRU_EN: tree pseudo-LRU victim selection instead of per-set round-robin.
//
// state | meaning
// IDLE  | lookups and fills serviced
// FLUSH | clearing valid + replacement state of one set per cycle, busy high
module d_sa_tag_ctrl
  import d_cache_pkg::*;
#(
  parameter  int ADDR_W   = DC_ADDR_W,
  parameter  int SETS     = DC_SETS,
  parameter  int WAYS     = DC_WAYS,
  parameter  int OFFSET_W = DC_OFFSET_W,
  localparam int SET_W    = $clog2(SETS),
  localparam int WAY_W    = $clog2(WAYS),
  localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic                   rsp_miss,
  output logic [WAY_W-1:0]       rsp_way,
  output logic [SET_W+WAY_W-1:0] rsp_line,
  output logic [WAY_W-1:0]       rsp_victim,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [SET_W-1:0]       rsp_set,
  output logic [OFFSET_W-1:0]    rsp_offset,
  input  logic                   fill_valid,
  input  logic [SET_W-1:0]       fill_set,
  input  logic [WAY_W-1:0]       fill_way,
  input  logic [TAG_W-1:0]       fill_tag,
  input  logic                   inv_all,
  output logic                   busy
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                    state_q;
  logic                      busy_q;
  logic [SET_W-1:0]          flush_cnt_q;

  logic [TAG_W-1:0]          tag_mem [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0] valid_q;
  repl_state_t               repl_q [SETS];
  repl_state_t               repl_nxt [SETS];
  logic [WAY_W-1:0]          repl_victim [SETS];

  logic                      pend_q;
  logic [TAG_W-1:0]          tag_q;
  logic [SET_W-1:0]          set_q;
  logic [OFFSET_W-1:0]       off_q;

  logic                      req_fire;
  logic                      fill_en;
  logic                      inv_found;
  logic [WAY_W-1:0]          inv_way;
  lookup_rsp_t               lk;

  // Fill beats lookup for the port; fills are dropped while flushing.
  assign req_ready = ~busy_q & ~fill_valid;
  assign req_fire  = req_valid & req_ready;
  assign fill_en   = fill_valid & ~busy_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inv_all) begin
            state_q     <= FLUSH;
            busy_q      <= 1'b1;
            flush_cnt_q <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == SET_W'(SETS-1)) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + SET_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      tag_q  <= '0;
      set_q  <= '0;
      off_q  <= '0;
    end else begin
      pend_q <= req_fire;
      if (req_fire) begin
        tag_q <= addr_tag(req_addr);
        set_q <= addr_set(req_addr);
        off_q <= addr_offset(req_addr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[fill_set][fill_way] <= fill_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < SETS; s++) repl_q[s] <= '0;
    end else if (busy_q) begin
      valid_q[flush_cnt_q] <= '0;
      repl_q[flush_cnt_q]  <= '0;
    end else begin
      if (fill_en) valid_q[fill_set][fill_way] <= 1'b1;
      for (int s = 0; s < SETS; s++) repl_q[s] <= repl_nxt[s];
    end
  end

  // Compare sees the arrays before this cycle's writes; descending scan leaves the lowest way.
  always_comb begin
    lk        = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[set_q][w] && (tag_mem[set_q][w] == tag_q)) begin
        lk.hit = 1'b1;
        lk.way = WAY_W'(w);
      end
      if (!valid_q[set_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    lk.victim = inv_found ? inv_way : repl_victim[set_q];
  end

`ifdef DCACHE_PLRU_EN
  for (genvar s = 0; s < SETS; s++) begin : g_plru
    d_plru_tree #(.WAYS(WAYS)) u_plru (
      .state      (repl_q[s]),
      .hit_en     (rsp_hit && (set_q == SET_W'(s))),
      .hit_way    (rsp_way),
      .fill_en    (fill_en && (fill_set == SET_W'(s))),
      .fill_way   (fill_way),
      .victim     (repl_victim[s]),
      .state_next (repl_nxt[s])
    );
  end
`else
  for (genvar s = 0; s < SETS; s++) begin : g_rr
    assign repl_victim[s] = repl_q[s];
    assign repl_nxt[s]    = (fill_en && (fill_set == SET_W'(s))) ? repl_q[s] + WAY_W'(1) : repl_q[s];
  end
`endif

  assign rsp_valid  = pend_q;
  assign rsp_hit    = pend_q & lk.hit;
  assign rsp_miss   = pend_q & ~lk.hit;
  assign rsp_way    = rsp_hit ? lk.way : '0;
  assign rsp_line   = {set_q, rsp_way};
  assign rsp_victim = pend_q ? lk.victim : '0;
  assign rsp_tag    = tag_q;
  assign rsp_set    = set_q;
  assign rsp_offset = off_q;

endmodule

// File: tb/tb_d_sa_tag_ctrl.sv
// Directed bench for d_sa_tag_ctrl: lookups, fills, replacement victim, invalidate-all and reset mid-flush.
module tb_d_sa_tag_ctrl;
  import d_cache_pkg::*;

`ifdef DCACHE_PLRU_EN
  localparam int EXP_VIC3 = 2;
`else
  localparam int EXP_VIC3 = 0;
`endif

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         req_valid;
  logic                         req_ready;
  logic [DC_ADDR_W-1:0]         req_addr;
  logic                         rsp_valid;
  logic                         rsp_hit;
  logic                         rsp_miss;
  logic [DC_WAY_W-1:0]          rsp_way;
  logic [DC_SET_W+DC_WAY_W-1:0] rsp_line;
  logic [DC_WAY_W-1:0]          rsp_victim;
  logic [DC_TAG_W-1:0]          rsp_tag;
  logic [DC_SET_W-1:0]          rsp_set;
  logic [DC_OFFSET_W-1:0]       rsp_offset;
  logic                         fill_valid;
  logic [DC_SET_W-1:0]          fill_set;
  logic [DC_WAY_W-1:0]          fill_way;
  logic [DC_TAG_W-1:0]          fill_tag;
  logic                         inv_all;
  logic                         busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  d_sa_tag_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_miss   (rsp_miss),
    .rsp_way    (rsp_way),
    .rsp_line   (rsp_line),
    .rsp_victim (rsp_victim),
    .rsp_tag    (rsp_tag),
    .rsp_set    (rsp_set),
    .rsp_offset (rsp_offset),
    .fill_valid (fill_valid),
    .fill_set   (fill_set),
    .fill_way   (fill_way),
    .fill_tag   (fill_tag),
    .inv_all    (inv_all),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [DC_ADDR_W-1:0] a);
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
  endtask

  task automatic fill(input logic [DC_SET_W-1:0] s, input logic [DC_WAY_W-1:0] w,
                      input logic [DC_TAG_W-1:0] t);
    fill_set   = s;
    fill_way   = w;
    fill_tag   = t;
    fill_valid = 1'b1;
    tick();
    fill_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    fill_valid = 1'b0;
    fill_set   = '0;
    fill_way   = '0;
    fill_tag   = '0;
    inv_all    = 1'b0;
    tick();
    tick();
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_hit",   32'(rsp_hit),   32'd0);
    chk("rst_rsp_miss",  32'(rsp_miss),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // cold miss on set 0
    lookup(32'h0000_0010);
    chk("t1_miss",   32'(rsp_miss),   32'd1);
    chk("t1_hit",    32'(rsp_hit),    32'd0);
    chk("t1_set",    32'(rsp_set),    32'd0);
    chk("t1_victim", 32'(rsp_victim), 32'd0);
    chk("t1_tag",    32'(rsp_tag),    32'h0000001);
    tick();
    chk("t1_one_cycle", 32'(rsp_valid), 32'd0);

    // fill then hit, echoed fields and global line number
    fill(2'd1, 2'd2, 28'hABCDEF1);
    lookup(32'hABCD_EF17);
    chk("t2_hit",    32'(rsp_hit),    32'd1);
    chk("t2_miss",   32'(rsp_miss),   32'd0);
    chk("t2_way",    32'(rsp_way),    32'd2);
    chk("t2_line",   32'(rsp_line),   32'd6);
    chk("t2_offset", 32'(rsp_offset), 32'd3);
    chk("t2_set",    32'(rsp_set),    32'd1);

    // full set, hit way 0, then replacement victim
    for (int w = 0; w < 4; w++) fill(2'd0, DC_WAY_W'(w), DC_TAG_W'(w + 1));
    lookup(32'h0000_0010);
    chk("t3_hit_tag1", 32'(rsp_hit), 32'd1);
    chk("t3_way_tag1", 32'(rsp_way), 32'd0);
    lookup(32'h0000_0050);
    chk("t3_miss",   32'(rsp_miss),   32'd1);
    chk("t3_way0",   32'(rsp_way),    32'd0);
    chk("t3_victim", 32'(rsp_victim), 32'(EXP_VIC3));

    // request in flight with inv_all, then flush window
    req_addr  = 32'hABCD_EF17;
    req_valid = 1'b1;
    inv_all   = 1'b1;
    tick();
    req_valid = 1'b0;
    inv_all   = 1'b0;
    chk("t4_inflight_hit", 32'(rsp_hit), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_busy_c%0d", i),  32'(busy),      32'd1);
      chk($sformatf("t4_ready_c%0d", i), 32'(req_ready), 32'd0);
      tick();
    end
    chk("t4_busy_done",  32'(busy),      32'd0);
    chk("t4_ready_done", 32'(req_ready), 32'd1);
    lookup(32'hABCD_EF17);
    chk("t4_stale_miss", 32'(rsp_miss),   32'd1);
    chk("t4_victim",     32'(rsp_victim), 32'd0);

    // fill blocks the request for one cycle, then the request hits the new tag
    fill_set   = 2'd2;
    fill_way   = 2'd1;
    fill_tag   = 28'h0000123;
    fill_valid = 1'b1;
    req_addr   = 32'h0000_1238;
    req_valid  = 1'b1;
    #1;
    chk("t5_ready_blocked", 32'(req_ready), 32'd0);
    tick();
    fill_valid = 1'b0;
    #1;
    chk("t5_no_accept", 32'(rsp_valid), 32'd0);
    chk("t5_ready",     32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t5_hit",       32'(rsp_hit),   32'd1);
    chk("t5_way",       32'(rsp_way),   32'd1);

    fill(2'd3, 2'd3, 28'h0000007);
    lookup(32'h0000_007C);
    chk("t5_set3_hit", 32'(rsp_hit), 32'd1);
    chk("t5_set3_way", 32'(rsp_way), 32'd3);

    // async reset in the second flush cycle
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    tick();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst",      32'(busy),      32'd0);
    chk("t6_rsp_valid_rst", 32'(rsp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    lookup(32'h0000_0010);
    chk("t6_miss_set0", 32'(rsp_miss), 32'd1);
    lookup(32'hABCD_EF17);
    chk("t6_miss_set1", 32'(rsp_miss), 32'd1);
    lookup(32'h0000_1238);
    chk("t6_miss_set2", 32'(rsp_miss), 32'd1);
    lookup(32'h0000_007C);
    chk("t6_miss_set3", 32'(rsp_miss), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
